// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths and field indices for the MEM pipeline stage.
//   ES2MS_LEN     : EXE -> MEM bus width
//   MS2WS_LEN     : MEM -> WB bus width
//   MS_RF_ZIP_LEN : forwarding bundle width
//   LD_*          : bit positions of the one-hot load opcode field
package mem_stage_pkg;

  localparam int ES2MS_LEN     = 83;
  localparam int MS2WS_LEN     = 77;
  localparam int MS_RF_ZIP_LEN = 39;
  localparam int DATA_W        = 32;

  // ld_op = {ld_b, ld_bu, ld_h, ld_hu, ld_w}
  localparam int LD_OP_W = 5;
  localparam int LD_B    = 4;
  localparam int LD_BU   = 3;
  localparam int LD_H    = 2;
  localparam int LD_HU   = 1;
  localparam int LD_W    = 0;

  localparam int DISCARD_W = 2;

endpackage

// File: rtl/mem_stage_load_align.sv
// mem_load_align: combinational load-data alignment and extension.
//   ld_op [4:0] : one-hot {ld_b, ld_bu, ld_h, ld_hu, ld_w}
//   addr  [1:0] : low address bits selecting byte / halfword
//   rdata [31:0]: raw word returned by data memory
//   value [31:0]: aligned, sign/zero-extended load result
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [LD_OP_W-1:0] ld_op,
  input  logic [1:0]         addr,
  input  logic [DATA_W-1:0]  rdata,
  output logic [DATA_W-1:0]  value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    value = '0;
    if (ld_op[LD_W])       value = rdata;
    else if (ld_op[LD_B])  value = {{24{byte_sel[7]}}, byte_sel};
    else if (ld_op[LD_BU]) value = {24'd0, byte_sel};
    else if (ld_op[LD_H])  value = {{16{half_sel[15]}}, half_sel};
    else if (ld_op[LD_HU]) value = {16'd0, half_sel};
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Holds one instruction, waits for the data
// memory response on loads/stores, buffers the response if WB stalls, and
// drops responses that belong to requests flushed by WB.
//   clk, resetn          : clock, synchronous active-low reset
//   es2ms_valid/bus      : instruction from EXE
//   ms_allowin           : stage can accept this cycle
//   ws_allowin           : WB can accept this cycle
//   ms2ws_valid/bus      : completed instruction to WB
//   data_sram_data_ok    : response strobe for an outstanding data request
//   data_sram_rdata      : read data, valid with data_ok
//   wb_ex                : flush from WB
//   ms_ex                : valid instruction carrying an exception
//   ms_rf_zip            : forwarding {ld_pending, we, waddr, wdata}
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     es2ms_valid,
  input  logic [ES2MS_LEN-1:0]     es2ms_bus,
  output logic                     ms_allowin,
  input  logic                     ws_allowin,
  output logic                     ms2ws_valid,
  output logic [MS2WS_LEN-1:0]     ms2ws_bus,
  input  logic                     data_sram_data_ok,
  input  logic [DATA_W-1:0]        data_sram_rdata,
  input  logic                     wb_ex,
  output logic                     ms_ex,
  output logic [MS_RF_ZIP_LEN-1:0] ms_rf_zip
);

  logic                 ms_valid;
  logic [ES2MS_LEN-1:0] bus_p0;
  logic                 buf_valid;
  logic [DATA_W-1:0]    buf_data;
  logic [DISCARD_W-1:0] discard_cnt;

  logic                 mem_req;
  logic [LD_OP_W-1:0]   ld_op;
  logic [31:0]          pc;
  logic                 rf_we;
  logic [4:0]           rf_waddr;
  logic [DATA_W-1:0]    alu_result;
  logic [6:0]           except;

  logic                 data_ok_acc;
  logic                 data_ok_seen;
  logic                 ms_ready_go;
  logic                 ld_pending;
  logic                 disc_inc;
  logic                 disc_dec;
  logic [DATA_W-1:0]    load_src;
  logic [DATA_W-1:0]    load_value;
  logic [DATA_W-1:0]    rf_wdata;

  assign {mem_req, ld_op, pc, rf_we, rf_waddr, alu_result, except} = bus_p0;

  // A response only counts for the current instruction when nothing is
  // still owed to a flushed request.
  assign data_ok_acc  = data_sram_data_ok & (discard_cnt == '0);
  assign data_ok_seen = data_ok_acc | buf_valid;
  assign ms_ready_go  = ~mem_req | data_ok_seen;
  assign ms_allowin   = ~ms_valid | (ms_ready_go & ws_allowin);
  assign ms2ws_valid  = ms_valid & ms_ready_go;
  assign ms_ex        = ms_valid & (|except);
  assign ld_pending   = ms_valid & (|ld_op) & ~data_ok_seen;

  assign disc_inc = wb_ex & ms_valid & mem_req & ~data_ok_seen;
  assign disc_dec = data_sram_data_ok & (discard_cnt != '0);

  assign load_src = buf_valid ? buf_data : data_sram_rdata;

  mem_load_align u_align (
    .ld_op (ld_op),
    .addr  (alu_result[1:0]),
    .rdata (load_src),
    .value (load_value)
  );

  assign rf_wdata  = (|ld_op) ? load_value : alu_result;
  assign ms2ws_bus = {pc, rf_we, rf_waddr, rf_wdata, except};
  assign ms_rf_zip = {ld_pending, rf_we & ms_valid, rf_waddr, rf_wdata};

  // ---- stage register (EXE -> MEM boundary) ----
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid <= 1'b0;
      bus_p0   <= '0;
    end else begin
      if (wb_ex)           ms_valid <= 1'b0;
      else if (ms_allowin) ms_valid <= es2ms_valid;
      if (es2ms_valid && ms_allowin) bus_p0 <= es2ms_bus;
    end
  end

  // Response buffer: holds read data while WB is stalled so the memory
  // side never has to repeat it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
    end else if (wb_ex || (ms2ws_valid && ws_allowin)) begin
      buf_valid <= 1'b0;
    end else if (ms_valid && mem_req && data_ok_acc && !ws_allowin) begin
      buf_valid <= 1'b1;
      buf_data  <= data_sram_rdata;
    end
  end

  // Responses still owed to flushed requests; saturating, and a
  // simultaneous increment/decrement cancels.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      discard_cnt <= '0;
    end else if (disc_inc && !disc_dec) begin
      if (discard_cnt != '1) discard_cnt <= discard_cnt + 1'b1;
    end else if (disc_dec && !disc_inc) begin
      discard_cnt <= discard_cnt - 1'b1;
    end
  end

endmodule
